// File: rtl/dmem_bridge_pkg.sv
// Shared types and defaults for the data-memory bus bridge.
// Holds the FSM state encoding and the default timeout and abort-data values.
package dmem_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_DONE   = 2'd3
    } bridge_state_e;

    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;
    localparam logic [31:0] DEF_ABORT_RDATA    = 32'h0000_0000;
    localparam int unsigned TMO_W              = 16;

endpackage

// File: rtl/dmem_bridge_timeout.sv
// Transaction watchdog: counts cycles spent in REQ/WAIT_R and flags when the
// limit is reached. Only instantiated when DMEM_BUS_BRIDGE_TIMEOUT_EN is defined.
module dmem_bridge_timeout
    import dmem_bridge_pkg::*;
#(
    parameter int unsigned LIMIT = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TMO_W-1:0] LAST = TMO_W'(LIMIT - 1);

    logic [TMO_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    // The first REQ cycle sees count == 0, so LIMIT active cycles end on LAST.
    assign expired = en && (count == LAST);

endmodule

// File: rtl/dmem_bus_bridge.sv
// Bridges the core's single-cycle data port onto a valid/ready request bus with
// a separate read-data return. Optional watchdog: DMEM_BUS_BRIDGE_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | no transaction; a request launches one and stalls the core
// REQ     | bus_valid held with stable address/data until bus_ready
// WAIT_R  | read accepted, waiting for bus_rvalid
// DONE    | single retire cycle with the stall released
module dmem_bus_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter logic [31:0] ABORT_RDATA    = DEF_ABORT_RDATA
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wd,
    input  logic        cpu_we,
    input  logic        cpu_re,
    input  logic [3:0]  cpu_strobe,
    output logic [31:0] cpu_rd,
    output logic        cpu_stall,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_strobe,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        timeout_err
);

    bridge_state_e state, state_nxt;

    logic cpu_req;
    logic launch;
    logic rd_capture;
    logic abort;
    logic tmo_expired;

    assign cpu_req = cpu_re | cpu_we;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        launch     = 1'b0;
        rd_capture = 1'b0;
        abort      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cpu_req) begin
                    launch    = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus_ready) begin
                    if (bus_we) begin
                        state_nxt = ST_DONE;
                    end else if (bus_rvalid) begin
                        rd_capture = 1'b1;
                        state_nxt  = ST_DONE;
                    end else begin
                        state_nxt = ST_WAIT_R;
                    end
                end else if (tmo_expired) begin
                    abort     = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_WAIT_R: begin
                if (bus_rvalid) begin
                    rd_capture = 1'b1;
                    state_nxt  = ST_DONE;
                end else if (tmo_expired) begin
                    abort     = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus_valid = (state == ST_REQ);
    assign cpu_stall = ((state == ST_IDLE) && cpu_req) ||
                       (state == ST_REQ) || (state == ST_WAIT_R);

    // A simultaneous load+store is treated as a store by latching cpu_we as-is.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            bus_addr   <= '0;
            bus_we     <= 1'b0;
            bus_wdata  <= '0;
            bus_strobe <= '0;
        end else if (launch) begin
            bus_addr   <= {cpu_addr[31:2], 2'b00};
            bus_we     <= cpu_we;
            bus_wdata  <= cpu_wd;
            bus_strobe <= cpu_strobe;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            cpu_rd <= '0;
        end else if (abort) begin
            cpu_rd <= ABORT_RDATA;
        end else if (rd_capture) begin
            cpu_rd <= bus_rdata;
        end
    end

`ifdef DMEM_BUS_BRIDGE_TIMEOUT_EN
    dmem_bridge_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (launch),
        .en      ((state == ST_REQ) || (state == ST_WAIT_R)),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            timeout_err <= 1'b0;
        end else if (abort) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign tmo_expired = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Self-checking bench for dmem_bus_bridge: scoreboarded transactions with a
// cycle-driven bus responder, plus timeout and reset-abandon scenarios.
module tb_dmem_bus_bridge;
    import dmem_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wd;
    logic        cpu_we;
    logic        cpu_re;
    logic [3:0]  cpu_strobe;
    logic [31:0] cpu_rd;
    logic        cpu_stall;
    logic        bus_valid;
    logic        bus_ready;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_strobe;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        timeout_err;

    typedef struct {
        logic [31:0] rd;
        int          stall;
        int          valid;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    dmem_bus_bridge #(
        .TIMEOUT_CYCLES (4),
        .ABORT_RDATA    (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cpu_addr    (cpu_addr),
        .cpu_wd      (cpu_wd),
        .cpu_we      (cpu_we),
        .cpu_re      (cpu_re),
        .cpu_strobe  (cpu_strobe),
        .cpu_rd      (cpu_rd),
        .cpu_stall   (cpu_stall),
        .bus_valid   (bus_valid),
        .bus_ready   (bus_ready),
        .bus_addr    (bus_addr),
        .bus_we      (bus_we),
        .bus_wdata   (bus_wdata),
        .bus_strobe  (bus_strobe),
        .bus_rvalid  (bus_rvalid),
        .bus_rdata   (bus_rdata),
        .timeout_err (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_bus_valid", 32'(bus_valid), 32'd0);
        chk("rst_bus_we", 32'(bus_we), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_bus_strobe", {28'd0, bus_strobe}, 32'd0);
        chk("rst_cpu_rd", cpu_rd, 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
    endtask

    task automatic do_reset();
        cpu_re = 1'b0; cpu_we = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        @(negedge clk);
    endtask

    // Called at a falling edge. ready_at: bus_valid cycle (1-based) on which
    // bus_ready is raised, 0 = never. rv_lag: cycles from acceptance to rvalid.
    task automatic run_txn(input logic re, input logic we, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] strb,
                           input int ready_at, input int rv_lag, input logic [31:0] rdata,
                           input logic [31:0] exp_rd, input int exp_stall, input int exp_valid);
        exp_t        e;
        exp_t        got;
        logic [31:0] exp_addr;
        int          stall_cnt = 0;
        int          valid_cnt = 0;
        int          acc_cyc   = -1;
        bit          done      = 1'b0;
        e.rd = exp_rd; e.stall = exp_stall; e.valid = exp_valid;
        sb.push_back(e);
        exp_addr   = addr & 32'hFFFF_FFFC;
        cpu_re     = re;
        cpu_we     = we;
        cpu_addr   = addr;
        cpu_wd     = wd;
        cpu_strobe = strb;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            #1;
            if (bus_valid) begin
                valid_cnt++;
                chk("bus_addr", bus_addr, exp_addr);
                chk("bus_strobe", {28'd0, bus_strobe}, {28'd0, strb});
                chk("bus_we", 32'(bus_we), 32'(we));
                chk("bus_wdata", bus_wdata, wd);
            end
            if (cyc > 0 && !cpu_stall) begin
                done = 1'b1;
                got  = sb.pop_front();
                chk("cpu_rd", cpu_rd, got.rd);
                chk("stall_cycles", stall_cnt, got.stall);
                chk("valid_cycles", valid_cnt, got.valid);
            end else begin
                if (cpu_stall) stall_cnt++;
                bus_ready = bus_valid && ready_at > 0 && valid_cnt >= ready_at;
                if (bus_ready) acc_cyc = cyc;
                bus_rvalid = !we && acc_cyc >= 0 && cyc == acc_cyc + rv_lag;
                bus_rdata  = bus_rvalid ? rdata : $urandom();
                @(negedge clk);
            end
        end
        if (!done) begin
            chk("txn_completed", 32'd0, 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
            do_reset();
        end else begin
            // Request still present through DONE; stray rvalid in DONE and IDLE.
            cpu_re = 1'b0; cpu_we = 1'b0; bus_ready = 1'b0;
            bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
            @(negedge clk); #1;
            chk("no_relaunch", 32'(bus_valid), 32'd0);
            chk("idle_stall", 32'(cpu_stall), 32'd0);
            chk("rd_hold_done", cpu_rd, exp_rd);
            @(negedge clk); #1;
            chk("rd_hold_idle", cpu_rd, exp_rd);
            bus_rvalid = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        cpu_addr = '0; cpu_wd = '0; cpu_strobe = '0; bus_rdata = '0;
        do_reset();

        // store: aligned address, one bus_valid cycle, 2 stall cycles
        run_txn(1'b0, 1'b1, 32'h0000_1006, 32'hAABB_CCDD, 4'b1100, 1, 0, 32'h0,
                32'h0, 2, 1);
        // load: ready on 3rd valid cycle, rvalid 2 cycles after acceptance
        run_txn(1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'b1111, 3, 2, 32'h1234_5678,
                32'h1234_5678, 6, 3);
        // load: ready and rvalid coincident, WAIT_R skipped
        run_txn(1'b1, 1'b0, 32'h0000_2004, 32'h0, 4'b1111, 1, 0, 32'hCAFE_F00D,
                32'hCAFE_F00D, 2, 1);
        // load+store together behaves as store, cpu_rd untouched
        run_txn(1'b1, 1'b1, 32'h0000_3008, 32'h1122_3344, 4'b1111, 2, 0, 32'h0,
                32'hCAFE_F00D, 3, 2);
        // narrow load from unaligned address
        run_txn(1'b1, 1'b0, 32'h0000_4ABC, 32'h0, 4'b0011, 2, 1, 32'h0BAD_CAFE,
                32'h0BAD_CAFE, 4, 2);

`ifdef DMEM_BUS_BRIDGE_TIMEOUT_EN
        run_txn(1'b1, 1'b0, 32'h0000_5000, 32'h0, 4'b1111, 0, 0, 32'h0,
                32'h0000_0000, 5, 4);
        chk("timeout_err_set", 32'(timeout_err), 32'd1);
        run_txn(1'b1, 1'b0, 32'h0000_5100, 32'h0, 4'b1111, 1, 0, 32'h600D_F00D,
                32'h600D_F00D, 2, 1);
        chk("timeout_err_sticky", 32'(timeout_err), 32'd1);
`else
        cpu_re = 1'b1; cpu_addr = 32'h0000_5000; cpu_strobe = 4'b1111; bus_ready = 1'b0;
        for (int i = 0; i < 20; i++) @(negedge clk);
        #1;
        chk("stall_persists", 32'(cpu_stall), 32'd1);
        chk("valid_persists", 32'(bus_valid), 32'd1);
        chk("timeout_err_tied", 32'(timeout_err), 32'd0);
        chk("rd_unchanged_wait", cpu_rd, 32'h0BAD_CAFE);
`endif
        do_reset();

        // reset while waiting for read data, then a late rvalid
        cpu_re = 1'b1; cpu_addr = 32'h0000_6000; cpu_strobe = 4'b1111;
        #1;
        chk("w_stall_idle", 32'(cpu_stall), 32'd1);
        @(negedge clk); #1;
        chk("w_valid_req", 32'(bus_valid), 32'd1);
        bus_ready = 1'b1;
        @(negedge clk); #1;
        chk("w_valid_drop", 32'(bus_valid), 32'd0);
        chk("w_stall_waitr", 32'(cpu_stall), 32'd1);
        bus_ready = 1'b0; cpu_re = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h5555_AAAA;
        #1;
        check_reset_vals();
        @(negedge clk); #1;
        chk("late_rvalid_ignored", cpu_rd, 32'd0);
        chk("late_rvalid_no_valid", 32'(bus_valid), 32'd0);
        bus_rvalid = 1'b0;

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
